// File: rtl/s_axis_rq_adapt_if.sv
// Stream bundle between the LitePCIe TLP source and the UltraScale+ RQ port.
// Latency: n/a (signal bundle only).
// Backpressure: tready on the TLP side and tready_a on the RQ side.
// Ports (slave = adapter view):
//   s_axis_rq_t*      TLP stream in (tdata/tkeep/tlast/tvalid), tready out
//   s_axis_rq_t*_a    RQ stream out (tdata/tkeep/tlast/tuser/tvalid), tready_a in
interface s_axis_rq_adapt_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
);
    logic [DATA_WIDTH-1:0]    s_axis_rq_tdata;
    logic [KEEP_WIDTH-1:0]    s_axis_rq_tkeep;
    logic                     s_axis_rq_tlast;
    logic                     s_axis_rq_tvalid;
    logic [3:0]               s_axis_rq_tready;

    logic [DATA_WIDTH-1:0]    s_axis_rq_tdata_a;
    logic [DATA_WIDTH/32-1:0] s_axis_rq_tkeep_a;
    logic                     s_axis_rq_tlast_a;
    logic [136:0]             s_axis_rq_tuser_a;
    logic                     s_axis_rq_tvalid_a;
    logic [3:0]               s_axis_rq_tready_a;

    // Adapter side.
    modport slave (
        input  s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tvalid,
        output s_axis_rq_tready,
        output s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a,
               s_axis_rq_tuser_a, s_axis_rq_tvalid_a,
        input  s_axis_rq_tready_a
    );

    // Environment side: TLP source plus RQ sink.
    modport master (
        output s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tvalid,
        input  s_axis_rq_tready,
        input  s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a,
               s_axis_rq_tuser_a, s_axis_rq_tvalid_a,
        output s_axis_rq_tready_a
    );
endinterface

// File: rtl/s_axis_rq_adapt.sv
// LitePCIe TLP -> UltraScale+ 512b RQ adapter: rewrites MRd/MWr headers into RQ descriptors, realigns 3DW payload.
// Latency: 0 cycles (combinational data path); one extra flush beat when a 3DW write's last DW spills over.
// Backpressure: tready follows tready_a[0]; held low during the flush beat and in reset; state frozen while stalled.
// Ports:
//   user_clk, user_reset   clock, synchronous active-high reset
//   rq (slave modport)     TLP stream in, RQ stream out (see s_axis_rq_adapt_if)
module s_axis_rq_adapt #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
    input  logic              user_clk,
    input  logic              user_reset,
    s_axis_rq_adapt_if.slave  rq
);
    localparam int NDW = DATA_WIDTH/32;

    typedef enum logic [1:0] {
        ST_SOP   = 2'd0,
        ST_PASS  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] carry;
    logic [31:0] carry_nxt;

    logic [NDW-1:0][31:0]  in_dw;
    logic [KEEP_WIDTH-1:0] keep_in;
    logic [NDW-1:0]        in_dwk;

    assign in_dw   = rq.s_axis_rq_tdata;
    assign keep_in = rq.s_axis_rq_tkeep;

    // DW-granular view of the byte keep: only the lowest byte lane of each DW is looked at.
    always_comb begin
        in_dwk = '0;
        for (int i = 0; i < NDW; i++) begin
            in_dwk[i] = keep_in[4*i];
        end
    end

    // ------------------------------------------------------------------
    // Header decode (only meaningful on the SOP beat)
    // ------------------------------------------------------------------
    logic [9:0]  h_len;
    logic [1:0]  h_attr;
    logic        h_ep;
    logic [2:0]  h_tc;
    logic        h_4dw;
    logic        h_data;
    logic [3:0]  h_fbe;
    logic [3:0]  h_lbe;
    logic [7:0]  h_tag;
    logic [15:0] h_rid;
    logic [63:0] h_addr;

    assign h_len  = in_dw[0][9:0];
    assign h_attr = in_dw[0][13:12];
    assign h_ep   = in_dw[0][14];
    assign h_tc   = in_dw[0][22:20];
    assign h_4dw  = in_dw[0][29];
    assign h_data = in_dw[0][30];
    assign h_fbe  = in_dw[1][3:0];
    assign h_lbe  = in_dw[1][7:4];
    assign h_tag  = in_dw[1][15:8];
    assign h_rid  = in_dw[1][31:16];
    // A 3DW header only carries a 32-bit address; the upper half is zero.
    assign h_addr = h_4dw ? {in_dw[2], in_dw[3][31:2], 2'b00}
                          : {32'h0, in_dw[2][31:2], 2'b00};

    // RQ descriptor. Dword count 0 in the TLP means 1024 DW, hence the extra MSB.
    logic [3:0][31:0] desc;
    assign desc[0] = {h_addr[31:2], 2'b00};                       // AT = untranslated
    assign desc[1] = h_addr[63:32];
    assign desc[2] = {h_rid, h_ep, 3'b000, h_data, (h_len == 10'd0), h_len};
    assign desc[3] = {1'b0, 1'b0, h_attr, h_tc, 1'b0, 16'h0000, h_tag};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic vld_a;
    logic rdy_in;
    logic fire;

    assign vld_a  = !user_reset && ((state == ST_FLUSH) || rq.s_axis_rq_tvalid);
    assign rdy_in = rq.s_axis_rq_tready_a[0] && (state != ST_FLUSH) && !user_reset;
    assign fire   = vld_a && rq.s_axis_rq_tready_a[0];

    assign rq.s_axis_rq_tready  = {4{rdy_in}};
    assign rq.s_axis_rq_tvalid_a = vld_a;

    // ------------------------------------------------------------------
    // Output beat formation and next-state decode
    // ------------------------------------------------------------------
    logic [NDW-1:0][31:0] out_dw;
    logic [NDW-1:0]       out_k;
    logic                 last_a;
    logic                 sop;

    always_comb begin
        out_dw    = '0;
        out_k     = '0;
        last_a    = 1'b0;
        sop       = 1'b0;
        state_nxt = state;
        carry_nxt = carry;
        case (state)
            ST_SOP: begin
                sop          = 1'b1;
                out_dw[3:0]  = desc;
                out_k[3:0]   = 4'hF;
                // Descriptor is 4DW: a 4DW header's payload already sits at DW4,
                // a 3DW header's payload starts at DW3 and moves up by one.
                if (h_4dw) begin
                    out_dw[NDW-1:4] = in_dw[NDW-1:4];
                    out_k[NDW-1:4]  = in_dwk[NDW-1:4];
                end else begin
                    out_dw[NDW-1:4] = in_dw[NDW-2:3];
                    out_k[NDW-1:4]  = in_dwk[NDW-2:3];
                end
                if (!h_data) begin
                    // Read request: descriptor only, always a single beat.
                    out_k  = '0;
                    out_k[3:0] = 4'hF;
                    last_a = 1'b1;
                end else if (h_4dw) begin
                    last_a = rq.s_axis_rq_tlast;
                    if (!rq.s_axis_rq_tlast) begin
                        state_nxt = ST_PASS;
                    end
                end else begin
                    carry_nxt = in_dw[NDW-1];
                    if (!rq.s_axis_rq_tlast) begin
                        state_nxt = ST_SHIFT;
                    end else if (h_len == 10'd13) begin
                        // 3 header + 13 payload fill the input beat; the last DW
                        // does not fit behind the descriptor and needs its own beat.
                        state_nxt = ST_FLUSH;
                    end else begin
                        last_a = 1'b1;
                    end
                end
            end
            ST_PASS: begin
                out_dw = in_dw;
                out_k  = in_dwk;
                last_a = rq.s_axis_rq_tlast;
                if (rq.s_axis_rq_tlast) begin
                    state_nxt = ST_SOP;
                end
            end
            ST_SHIFT: begin
                out_dw    = {in_dw[NDW-2:0], carry};
                out_k     = {in_dwk[NDW-2:0], 1'b1};
                carry_nxt = in_dw[NDW-1];
                if (rq.s_axis_rq_tlast) begin
                    if (in_dwk[NDW-1]) begin
                        state_nxt = ST_FLUSH;
                    end else begin
                        last_a    = 1'b1;
                        state_nxt = ST_SOP;
                    end
                end
            end
            ST_FLUSH: begin
                out_dw[0] = carry;
                out_k[0]  = 1'b1;
                last_a    = 1'b1;
                state_nxt = ST_SOP;
            end
            default: begin
                state_nxt = ST_SOP;
            end
        endcase
    end

    // End-of-packet pointer: highest kept DW of the closing beat.
    logic [3:0] eop_ptr;
    always_comb begin
        eop_ptr = '0;
        if (last_a) begin
            for (int i = 0; i < NDW; i++) begin
                if (out_k[i]) begin
                    eop_ptr = 4'(i);
                end
            end
        end
    end

    logic [136:0] tuser;
    always_comb begin
        tuser = '0;
        if (sop) begin
            tuser[3:0]  = h_fbe;
            tuser[11:8] = h_lbe;
            tuser[20]   = 1'b1;
        end
        tuser[27:26] = {1'b0, last_a};
        tuser[31:28] = eop_ptr;
    end

    assign rq.s_axis_rq_tdata_a = out_dw;
    assign rq.s_axis_rq_tkeep_a = out_k;
    assign rq.s_axis_rq_tlast_a = last_a;
    assign rq.s_axis_rq_tuser_a = tuser;

    // ------------------------------------------------------------------
    // State: advances only when the RQ side takes a beat, so a stall
    // leaves both the state and the carried DW untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state <= ST_SOP;
            carry <= '0;
        end else if (fire) begin
            state <= state_nxt;
            carry <= carry_nxt;
        end
    end

    // Header fields, byte lanes and ready bits that the adapter does not consume.
    logic unused_in;
    assign unused_in = ^{in_dw, keep_in, rq.s_axis_rq_tready_a};

endmodule

// File: tb/tb_s_axis_rq_adapt.sv
module tb_s_axis_rq_adapt;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    s_axis_rq_adapt_if bus ();

    s_axis_rq_adapt dut (
        .user_clk   (clk),
        .user_reset (rst),
        .rq         (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic [511:0] td;
        logic [63:0]  tk;
        logic         tl;
        logic         tv;
        logic         tra;
        logic         e_vld;
        logic         e_rdy;
        logic [511:0] e_data;
        logic [15:0]  e_keep;
        logic         e_last;
        logic [136:0] e_user;
    } vec_t;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    vec_t        vecs[$];
    beat_t       beats[$];
    logic [31:0] exp_pl[$];
    logic [31:0] got_pl[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] setdw(input logic [511:0] d, input int i, input logic [31:0] v);
        d[32*i +: 32] = v;
        return d;
    endfunction

    function automatic logic [511:0] fill(input logic [511:0] d, input int slot, input int n,
                                          input logic [31:0] base, input int start);
        for (int i = 0; i < n; i++) d[32*(slot+i) +: 32] = base + 32'(start + i);
        return d;
    endfunction

    function automatic logic [63:0] kdw(input int n);
        if (n >= 16) return '1;
        return (64'd1 << (4*n)) - 64'd1;
    endfunction

    function automatic logic [511:0] dwmask(input logic [15:0] k);
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) if (k[i]) m[32*i +: 32] = '1;
        return m;
    endfunction

    function automatic logic [136:0] mk_user(input logic [3:0] fbe, input logic [3:0] lbe,
                                             input logic sop, input logic eop, input logic [3:0] ptr);
        logic [136:0] u;
        u = '0;
        u[3:0] = fbe; u[11:8] = lbe; u[20] = sop; u[26] = eop; u[31:28] = ptr;
        return u;
    endfunction

    function automatic vec_t mk(input logic r, input logic [511:0] td, input logic [63:0] tk,
                                input logic tl, input logic tv, input logic tra,
                                input logic ev, input logic er, input logic [511:0] ed,
                                input logic [15:0] ek, input logic el, input logic [136:0] eu);
        vec_t v;
        v.rst = r; v.td = td; v.tk = tk; v.tl = tl; v.tv = tv; v.tra = tra;
        v.e_vld = ev; v.e_rdy = er; v.e_data = ed; v.e_keep = ek; v.e_last = el; v.e_user = eu;
        return v;
    endfunction

    task automatic drive(input logic [511:0] d, input logic [63:0] k, input logic l,
                         input logic v, input logic [3:0] ra);
        bus.s_axis_rq_tdata    = d;
        bus.s_axis_rq_tkeep    = k;
        bus.s_axis_rq_tlast    = l;
        bus.s_axis_rq_tvalid   = v;
        bus.s_axis_rq_tready_a = ra;
    endtask

    // Write request of len DW, payload base+0 .. base+len-1, split into input beats.
    task automatic add_wr(input bit four, input int len, input logic [31:0] base);
        logic [511:0] d;
        int idx;
        int slot;
        d = '0;
        d = setdw(d, 0, {1'b0, 1'b1, four, 19'd0, len[9:0]});
        d = setdw(d, 1, 32'h0000_0FFF);
        if (four) begin
            d = setdw(d, 2, 32'h0000_0002);
            d = setdw(d, 3, 32'h7000_0000);
            slot = 4;
        end else begin
            d = setdw(d, 2, 32'h7000_0000);
            slot = 3;
        end
        idx = 0;
        while (idx < len) begin
            d = setdw(d, slot, base + 32'(idx));
            exp_pl.push_back(base + 32'(idx));
            idx++;
            slot++;
            if (slot == 16 || idx == len) begin
                beats.push_back('{d, kdw(slot), idx == len});
                d = '0;
                slot = 0;
            end
        end
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] e;
        logic [511:0] m;
        logic [511:0] mrd6;
        logic [511:0] prev_d;
        logic [15:0]  prev_k;
        logic         prev_l;
        logic         prev_stall;
        logic         in_pend;
        logic         done;
        int           bi;
        int           nsop;
        int           neop;
        vec_t         v;

        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0, 4'h0);

        // ---------------- vector table ----------------
        // 0: reset holds both handshakes low even with a beat offered
        vecs.push_back(mk(1, '0, '1, 1, 1, 1,  0, 0, '0, '0, 0, '0));
        // 1: idle
        vecs.push_back(mk(0, '0, '0, 0, 0, 1,  0, 1, '0, '0, 0, '0));
        // 2: 3DW MRd len1 addr 1000_0040 tag 05 BE F/0
        d = setdw(setdw(setdw('0, 0, 32'h0000_0001), 1, 32'h0000_050F), 2, 32'h1000_0040);
        e = setdw(setdw(setdw('0, 0, 32'h1000_0040), 2, 32'h0000_0001), 3, 32'h0000_0005);
        vecs.push_back(mk(0, d, kdw(3), 1, 1, 1,  1, 1, e, 16'h000F, 1, mk_user(4'hF, 4'h0, 1, 1, 4'd3)));
        // 3: 3DW MWr len1 data DEADBEEF
        d = setdw(setdw(setdw(setdw('0, 0, 32'h4000_0001), 1, 32'h0000_070F), 2, 32'h2000_0000), 3, 32'hDEAD_BEEF);
        e = setdw(setdw(setdw(setdw('0, 0, 32'h2000_0000), 2, 32'h0000_0801), 3, 32'h0000_0007), 4, 32'hDEAD_BEEF);
        vecs.push_back(mk(0, d, kdw(4), 1, 1, 1,  1, 1, e, 16'h001F, 1, mk_user(4'hF, 4'h0, 1, 1, 4'd4)));
        // 4: 3DW MWr len13 in one beat -> header beat without tlast_a
        d = fill(setdw(setdw(setdw('0, 0, 32'h4000_000D), 1, 32'h0000_09FF), 2, 32'h3000_0000), 3, 13, 32'hB000_0000, 0);
        e = fill(setdw(setdw(setdw('0, 0, 32'h3000_0000), 2, 32'h0000_080D), 3, 32'h0000_0009), 4, 12, 32'hB000_0000, 0);
        vecs.push_back(mk(0, d, '1, 1, 1, 1,  1, 1, e, 16'hFFFF, 0, mk_user(4'hF, 4'hF, 1, 0, 4'd0)));
        // 5: flush beat carries DW12; next header offered but refused
        mrd6 = setdw(setdw(setdw('0, 0, 32'h0000_0002), 1, 32'h0000_06FF), 2, 32'h0000_1000);
        e = setdw('0, 0, 32'hB000_000C);
        vecs.push_back(mk(0, mrd6, kdw(3), 1, 1, 1,  1, 0, e, 16'h0001, 1, mk_user(4'h0, 4'h0, 0, 1, 4'd0)));
        // 6: that header is now taken and decoded as a header
        e = setdw(setdw(setdw('0, 0, 32'h0000_1000), 2, 32'h0000_0002), 3, 32'h0000_0006);
        vecs.push_back(mk(0, mrd6, kdw(3), 1, 1, 1,  1, 1, e, 16'h000F, 1, mk_user(4'hF, 4'hF, 1, 1, 4'd3)));
        // 7-10: 3DW MWr len32 as 13/16/3, with a stall on the final beat
        d = fill(setdw(setdw(setdw('0, 0, 32'h4000_0020), 1, 32'h0000_0CFF), 2, 32'h4000_0100), 3, 13, 32'hC000_0000, 0);
        e = fill(setdw(setdw(setdw('0, 0, 32'h4000_0100), 2, 32'h0000_0820), 3, 32'h0000_000C), 4, 12, 32'hC000_0000, 0);
        vecs.push_back(mk(0, d, '1, 0, 1, 1,  1, 1, e, 16'hFFFF, 0, mk_user(4'hF, 4'hF, 1, 0, 4'd0)));
        d = fill('0, 0, 16, 32'hC000_0000, 13);
        e = fill('0, 0, 16, 32'hC000_0000, 12);
        vecs.push_back(mk(0, d, '1, 0, 1, 1,  1, 1, e, 16'hFFFF, 0, mk_user(4'h0, 4'h0, 0, 0, 4'd0)));
        d = fill('0, 0, 3, 32'hC000_0000, 29);
        e = fill('0, 0, 4, 32'hC000_0000, 28);
        vecs.push_back(mk(0, d, kdw(3), 1, 1, 0,  1, 0, e, 16'h000F, 1, mk_user(4'h0, 4'h0, 0, 1, 4'd3)));
        vecs.push_back(mk(0, d, kdw(3), 1, 1, 1,  1, 1, e, 16'h000F, 1, mk_user(4'h0, 4'h0, 0, 1, 4'd3)));
        // 11-12: 4DW MWr len16 addr 1_0000_0000 TC3 attr2 rid 1234 tag 0A
        d = fill(setdw(setdw(setdw('0, 0, 32'h6030_2010), 1, 32'h1234_0AFF), 2, 32'h0000_0001), 4, 12, 32'hD000_0000, 0);
        e = fill(setdw(setdw(setdw('0, 1, 32'h0000_0001), 2, 32'h1234_0810), 3, 32'h2600_000A), 4, 12, 32'hD000_0000, 0);
        vecs.push_back(mk(0, d, '1, 0, 1, 1,  1, 1, e, 16'hFFFF, 0, mk_user(4'hF, 4'hF, 1, 0, 4'd0)));
        d = fill('0, 0, 4, 32'hD000_0000, 12);
        vecs.push_back(mk(0, d, kdw(4), 1, 1, 1,  1, 1, d, 16'h000F, 1, mk_user(4'h0, 4'h0, 0, 1, 4'd3)));
        // 13: 4DW MRd len0 (1024 DW) EP rid ABCD tag 33
        d = setdw(setdw(setdw(setdw('0, 0, 32'h2000_4000), 1, 32'hABCD_33FF), 2, 32'hFFFF_FFFF), 3, 32'h8765_4320);
        e = setdw(setdw(setdw(setdw('0, 0, 32'h8765_4320), 1, 32'hFFFF_FFFF), 2, 32'hABCD_8400), 3, 32'h0000_0033);
        vecs.push_back(mk(0, d, kdw(4), 1, 1, 1,  1, 1, e, 16'h000F, 1, mk_user(4'hF, 4'hF, 1, 1, 4'd3)));
        // 14-18: 3DW MWr len29 as 13/16 -> flush out of SHIFT, stalled once
        d = fill(setdw(setdw(setdw('0, 0, 32'h4000_001D), 1, 32'h0000_0DFF), 2, 32'h5000_0000), 3, 13, 32'hE000_0000, 0);
        e = fill(setdw(setdw(setdw('0, 0, 32'h5000_0000), 2, 32'h0000_081D), 3, 32'h0000_000D), 4, 12, 32'hE000_0000, 0);
        vecs.push_back(mk(0, d, '1, 0, 1, 1,  1, 1, e, 16'hFFFF, 0, mk_user(4'hF, 4'hF, 1, 0, 4'd0)));
        d = fill('0, 0, 16, 32'hE000_0000, 13);
        e = fill('0, 0, 16, 32'hE000_0000, 12);
        vecs.push_back(mk(0, d, '1, 1, 1, 1,  1, 1, e, 16'hFFFF, 0, mk_user(4'h0, 4'h0, 0, 0, 4'd0)));
        e = setdw('0, 0, 32'hE000_001C);
        vecs.push_back(mk(0, '0, '0, 0, 0, 0,  1, 0, e, 16'h0001, 1, mk_user(4'h0, 4'h0, 0, 1, 4'd0)));
        vecs.push_back(mk(0, '0, '0, 0, 0, 1,  1, 0, e, 16'h0001, 1, mk_user(4'h0, 4'h0, 0, 1, 4'd0)));
        vecs.push_back(mk(0, '0, '0, 0, 0, 1,  0, 1, '0, '0, 0, '0));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst;
            drive(v.td, v.tk, v.tl, v.tv, {4{v.tra}});
            @(negedge clk);
            chk($sformatf("v%0d tvalid_a", i), 512'(bus.s_axis_rq_tvalid_a), 512'(v.e_vld));
            chk($sformatf("v%0d tready", i), 512'(bus.s_axis_rq_tready), 512'({4{v.e_rdy}}));
            if (v.e_vld) begin
                m = dwmask(v.e_keep);
                chk($sformatf("v%0d tdata_a", i), bus.s_axis_rq_tdata_a & m, v.e_data & m);
                chk($sformatf("v%0d tkeep_a", i), 512'(bus.s_axis_rq_tkeep_a), 512'(v.e_keep));
                chk($sformatf("v%0d tlast_a", i), 512'(bus.s_axis_rq_tlast_a), 512'(v.e_last));
                chk($sformatf("v%0d tuser_a", i), 512'(bus.s_axis_rq_tuser_a), 512'(v.e_user));
            end
            @(posedge clk);
            #1;
        end

        // ---------------- random stalls across three packets ----------------
        add_wr(1'b0, 40, 32'hA100_0000);
        add_wr(1'b0, 29, 32'hA200_0000);
        add_wr(1'b1, 20, 32'hA300_0000);
        bi = 0; nsop = 0; neop = 0;
        in_pend = 1'b0; prev_stall = 1'b0; done = 1'b0;
        prev_d = '0; prev_k = '0; prev_l = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (!in_pend) begin
                if (bi < beats.size() && $urandom_range(0, 3) != 0) begin
                    drive(beats[bi].d, beats[bi].k, beats[bi].l, 1'b1, 4'h0);
                    in_pend = 1'b1;
                end else begin
                    bus.s_axis_rq_tvalid = 1'b0;
                end
            end
            bus.s_axis_rq_tready_a = ($urandom_range(0, 2) != 0) ? 4'hF : 4'h0;
            @(negedge clk);
            if (prev_stall) begin
                chk("hold tdata_a", bus.s_axis_rq_tdata_a, prev_d);
                chk("hold tkeep_a", 512'(bus.s_axis_rq_tkeep_a), 512'(prev_k));
                chk("hold tlast_a", 512'(bus.s_axis_rq_tlast_a), 512'(prev_l));
            end
            prev_stall = bus.s_axis_rq_tvalid_a && !bus.s_axis_rq_tready_a[0];
            prev_d = bus.s_axis_rq_tdata_a;
            prev_k = bus.s_axis_rq_tkeep_a;
            prev_l = bus.s_axis_rq_tlast_a;
            if (bus.s_axis_rq_tvalid_a && bus.s_axis_rq_tready_a[0]) begin
                for (int i = 0; i < 16; i++) begin
                    if (bus.s_axis_rq_tkeep_a[i] && !(bus.s_axis_rq_tuser_a[20] && i < 4))
                        got_pl.push_back(bus.s_axis_rq_tdata_a[32*i +: 32]);
                end
                if (bus.s_axis_rq_tuser_a[20]) nsop++;
                if (bus.s_axis_rq_tuser_a[26]) neop++;
            end
            if (bus.s_axis_rq_tvalid && bus.s_axis_rq_tready[0]) begin
                bi++;
                in_pend = 1'b0;
            end
            done = (bi == beats.size()) && (neop == 3) && !bus.s_axis_rq_tvalid_a;
            @(posedge clk);
            #1;
        end
        chk("stream completes in budget", 512'(done), 512'(1));
        chk("payload DW count", 512'(got_pl.size()), 512'(exp_pl.size()));
        for (int i = 0; i < exp_pl.size() && i < got_pl.size(); i++)
            chk($sformatf("payload DW%0d", i), 512'(got_pl[i]), 512'(exp_pl[i]));
        chk("sop beats", 512'(nsop), 512'(3));
        chk("eop beats", 512'(neop), 512'(3));

        // ---------------- reset in the middle of a shifted write ----------------
        beats.delete();
        exp_pl.delete();
        add_wr(1'b0, 40, 32'hA400_0000);
        drive(beats[0].d, beats[0].k, beats[0].l, 1'b1, 4'hF);
        @(negedge clk);
        chk("mid hdr tready", 512'(bus.s_axis_rq_tready), 512'(4'hF));
        @(posedge clk); #1;
        drive(beats[1].d, beats[1].k, beats[1].l, 1'b1, 4'hF);
        @(negedge clk);
        chk("mid carry DW0", 512'(bus.s_axis_rq_tdata_a[31:0]), 512'(32'hA400_000C));
        @(posedge clk); #1;
        rst = 1'b1;
        drive(beats[2].d, beats[2].k, beats[2].l, 1'b1, 4'hF);
        @(negedge clk);
        chk("rst tvalid_a", 512'(bus.s_axis_rq_tvalid_a), 512'(0));
        chk("rst tready", 512'(bus.s_axis_rq_tready), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        d = setdw(setdw(setdw(setdw('0, 0, 32'h4000_0001), 1, 32'h0000_110F), 2, 32'h6000_0000), 3, 32'h1234_5678);
        drive(d, kdw(4), 1'b1, 1'b1, 4'hF);
        @(negedge clk);
        chk("post-rst sop", 512'(bus.s_axis_rq_tuser_a[20]), 512'(1));
        chk("post-rst addr", 512'(bus.s_axis_rq_tdata_a[31:0]), 512'(32'h6000_0000));
        chk("post-rst DW4", 512'(bus.s_axis_rq_tdata_a[159:128]), 512'(32'h1234_5678));
        chk("post-rst keep", 512'(bus.s_axis_rq_tkeep_a), 512'(16'h001F));
        chk("post-rst tlast_a", 512'(bus.s_axis_rq_tlast_a), 512'(1));
        @(posedge clk); #1;
        drive('0, '0, 1'b0, 1'b0, 4'hF);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
